// File: rtl/dlsc_pcie_s6_outbound_read_alloc.sv
`default_nettype none
// ============================================================================
// Module   : dlsc_pcie_s6_outbound_read_alloc
// Purpose  : holds split read TLP headers until a tag and completion-buffer
//            space are free, stamps the tag, and releases both on completion.
// Revision : 1.0
// ============================================================================
module dlsc_pcie_s6_outbound_read_alloc #(
   parameter ADDR       = 32,
   parameter TAG        = 3,
   parameter CPL_BUF_DW = 512
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   output logic             cmd_ready,
   input  logic             cmd_valid,
   input  logic [ADDR-1:2]  cmd_addr,
   input  logic [9:0]       cmd_len,
   input  logic             tlp_h_ready,
   output logic             tlp_h_valid,
   output logic [ADDR-1:2]  tlp_h_addr,
   output logic [9:0]       tlp_h_len,
   output logic [TAG-1:0]   tlp_h_tag,
   input  logic             cpl_done_valid,
   input  logic [TAG-1:0]   cpl_done_tag,
   input  logic [TAG-1:0]   cpl_lookup_tag,
   output logic [9:0]       cpl_lookup_len,
   output logic [TAG:0]     outstanding,
   output logic [12:0]      free_dw,
   output logic             idle,
   output logic             cpl_err
);

   localparam int TAGS = 1 << TAG;
   localparam logic [TAGS-1:0] c_one_hot = {{(TAGS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_ISSUE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;

   logic [ADDR-1:2]   r_addr;
   logic [9:0]        r_len;
   logic [TAG-1:0]    r_tag;
   logic [TAGS-1:0]   r_busy;
   logic [TAG:0]      r_outstanding;
   logic [12:0]       r_free_dw;
   logic              r_cpl_err;
   logic [9:0]        r_len_mem [TAGS];

   logic [10:0]       w_len_dw;
   logic              w_res_ok;
   logic [TAG-1:0]    w_sel;
   logic              w_rel;
   logic [9:0]        w_rel_raw;
   logic [10:0]       w_rel_dw;
   logic [12:0]       w_res_amt;
   logic [12:0]       w_rel_amt;
   logic [TAGS-1:0]   w_rel_mask;
   logic [TAGS-1:0]   w_alloc_mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      cmd_ready    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            cmd_ready = enable & ~rst;
            if (cmd_ready && cmd_valid) w_state_next = ST_HOLD;
         end
         ST_HOLD: begin
            if (w_res_ok) w_state_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (tlp_h_ready) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Allocation decisions use only registered state, so a tag/space freed this
   // cycle becomes visible to the held command on the next cycle.
   assign w_len_dw = (r_len == 10'd0) ? 11'd1024 : {1'b0, r_len};
   assign w_res_ok = (r_state == ST_HOLD) && (~r_busy != '0) &&
                     ({2'b00, w_len_dw} <= r_free_dw);

   always_comb begin
      w_sel = '0;
      for (int i = TAGS-1; i >= 0; i--) begin
         if (!r_busy[i]) w_sel = TAG'(i);
      end
   end

   assign w_rel     = cpl_done_valid && r_busy[cpl_done_tag];
   assign w_rel_raw = r_len_mem[cpl_done_tag];
   assign w_rel_dw  = (w_rel_raw == 10'd0) ? 11'd1024 : {1'b0, w_rel_raw};

   assign w_res_amt    = w_res_ok ? {2'b00, w_len_dw} : 13'd0;
   assign w_rel_amt    = w_rel    ? {2'b00, w_rel_dw} : 13'd0;
   assign w_rel_mask   = w_rel    ? (c_one_hot << cpl_done_tag) : '0;
   assign w_alloc_mask = w_res_ok ? (c_one_hot << w_sel) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy        <= '0;
         r_outstanding <= '0;
         r_free_dw     <= 13'(CPL_BUF_DW);
         r_cpl_err     <= 1'b0;
      end else begin
         r_busy        <= (r_busy & ~w_rel_mask) | w_alloc_mask;
         r_outstanding <= r_outstanding + {{TAG{1'b0}}, w_res_ok}
                                         - {{TAG{1'b0}}, w_rel};
         r_free_dw     <= r_free_dw - w_res_amt + w_rel_amt;
         r_cpl_err     <= cpl_done_valid && !r_busy[cpl_done_tag];
      end
   end

   always_ff @(posedge clk) begin
      if (cmd_ready && cmd_valid) begin
         r_addr <= cmd_addr;
         r_len  <= cmd_len;
      end
      if (w_res_ok) begin
         r_tag            <= w_sel;
         r_len_mem[w_sel] <= r_len;
      end
   end

   assign tlp_h_valid    = (r_state == ST_ISSUE);
   assign tlp_h_addr     = r_addr;
   assign tlp_h_len      = r_len;
   assign tlp_h_tag      = r_tag;
   assign cpl_lookup_len = r_len_mem[cpl_lookup_tag];
   assign outstanding    = r_outstanding;
   assign free_dw        = r_free_dw;
   assign idle           = (r_busy == '0) && (r_state == ST_IDLE);
   assign cpl_err        = r_cpl_err;

endmodule
`default_nettype wire

// File: tb/tb_dlsc_pcie_s6_outbound_read_alloc.sv
`default_nettype none
// ============================================================================
// Module   : tb_dlsc_pcie_s6_outbound_read_alloc
// Purpose  : scoreboard bench for the outbound read tag/buffer allocator.
// Revision : 1.0
// ============================================================================
module tb_dlsc_pcie_s6_outbound_read_alloc;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        cmd_ready;
   logic        cmd_valid;
   logic [31:2] cmd_addr;
   logic [9:0]  cmd_len;
   logic        tlp_h_ready;
   logic        tlp_h_valid;
   logic [31:2] tlp_h_addr;
   logic [9:0]  tlp_h_len;
   logic [2:0]  tlp_h_tag;
   logic        cpl_done_valid;
   logic [2:0]  cpl_done_tag;
   logic [2:0]  cpl_lookup_tag;
   logic [9:0]  cpl_lookup_len;
   logic [3:0]  outstanding;
   logic [12:0] free_dw;
   logic        idle;
   logic        cpl_err;

   typedef struct packed {
      logic [29:0] addr;
      logic [9:0]  len;
      logic [2:0]  tag;
   } hdr_t;

   hdr_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   dlsc_pcie_s6_outbound_read_alloc #(
      .ADDR       (32),
      .TAG        (3),
      .CPL_BUF_DW (512)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .cmd_ready      (cmd_ready),
      .cmd_valid      (cmd_valid),
      .cmd_addr       (cmd_addr),
      .cmd_len        (cmd_len),
      .tlp_h_ready    (tlp_h_ready),
      .tlp_h_valid    (tlp_h_valid),
      .tlp_h_addr     (tlp_h_addr),
      .tlp_h_len      (tlp_h_len),
      .tlp_h_tag      (tlp_h_tag),
      .cpl_done_valid (cpl_done_valid),
      .cpl_done_tag   (cpl_done_tag),
      .cpl_lookup_tag (cpl_lookup_tag),
      .cpl_lookup_len (cpl_lookup_len),
      .outstanding    (outstanding),
      .free_dw        (free_dw),
      .idle           (idle),
      .cpl_err        (cpl_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Returns one cycle after the handshake edge.
   task automatic send_cmd(input logic [29:0] a, input logic [9:0] l,
                           input logic [2:0] t, input bit push);
      int k;
      hdr_t h;
      cmd_addr  = a;
      cmd_len   = l;
      cmd_valid = 1'b1;
      k = 0;
      @(negedge clk);
      while (!cmd_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (!cmd_ready) chk("cmd_accept_timeout", 32'd0, 32'd1);
      else if (push) begin
         h.addr = a; h.len = l; h.tag = t;
         sb.push_back(h);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic release_tag(input logic [2:0] t);
      cpl_done_valid = 1'b1;
      cpl_done_tag   = t;
      @(posedge clk);
      #1;
      cpl_done_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && tlp_h_valid && tlp_h_ready) begin
         if (sb.size() == 0) chk("unexpected_hdr", 32'd1, 32'd0);
         else begin
            hdr_t e;
            e = sb.pop_front();
            chk("hdr_addr", 32'(tlp_h_addr), 32'(e.addr));
            chk("hdr_len",  32'(tlp_h_len),  32'(e.len));
            chk("hdr_tag",  32'(tlp_h_tag),  32'(e.tag));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; enable = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
      tlp_h_ready = 1'b1; cpl_done_valid = 1'b0; cpl_done_tag = '0; cpl_lookup_tag = '0;
      step(3);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_valid",     32'(tlp_h_valid), 32'd0);
      chk("rst_outst",     32'(outstanding), 32'd0);
      chk("rst_free",      32'(free_dw), 32'd512);
      chk("rst_idle",      32'(idle), 32'd1);
      chk("rst_cpl_err",   32'(cpl_err), 32'd0);
      rst = 1'b0; enable = 1'b1;
      step(1);

      // Single command, latency and release
      send_cmd(30'h400, 10'd32, 3'd0, 1'b1);
      chk("t1_valid_n1", 32'(tlp_h_valid), 32'd0);
      step(1);
      chk("t1_valid_n2", 32'(tlp_h_valid), 32'd1);
      chk("t1_tag",      32'(tlp_h_tag), 32'd0);
      chk("t1_free",     32'(free_dw), 32'd480);
      chk("t1_outst",    32'(outstanding), 32'd1);
      step(1);
      chk("t1_valid_off", 32'(tlp_h_valid), 32'd0);
      chk("t1_not_idle",  32'(idle), 32'd0);
      release_tag(3'd0);
      chk("t1_free_rel",  32'(free_dw), 32'd512);
      chk("t1_idle",      32'(idle), 32'd1);
      chk("t1_outst_rel", 32'(outstanding), 32'd0);

      // Tag exhaustion
      for (int i = 0; i < 8; i++) send_cmd(30'h800 + 30'(i*4), 10'd16, 3'(i), 1'b1);
      step(3);
      chk("t2_outst8", 32'(outstanding), 32'd8);
      chk("t2_free",   32'(free_dw), 32'd384);
      cpl_lookup_tag = 3'd3;
      #1 chk("t2_lookup", 32'(cpl_lookup_len), 32'd16);
      send_cmd(30'h900, 10'd16, 3'd5, 1'b1);
      step(5);
      chk("t2_stall_ready", 32'(cmd_ready), 32'd0);
      chk("t2_stall_valid", 32'(tlp_h_valid), 32'd0);
      release_tag(3'd5);
      chk("t2_valid_r1", 32'(tlp_h_valid), 32'd0);
      chk("t2_outst7",   32'(outstanding), 32'd7);
      step(1);
      chk("t2_valid_r2", 32'(tlp_h_valid), 32'd1);
      chk("t2_tag5",     32'(tlp_h_tag), 32'd5);
      step(1);
      for (int i = 0; i < 8; i++) release_tag(3'(i));
      chk("t2_free_end", 32'(free_dw), 32'd512);
      chk("t2_idle_end", 32'(idle), 32'd1);

      // Buffer exhaustion
      send_cmd(30'h1000, 10'd256, 3'd0, 1'b1);
      send_cmd(30'h1100, 10'd256, 3'd1, 1'b1);
      send_cmd(30'h1200, 10'd1,   3'd0, 1'b1);
      step(4);
      chk("t3_free0",  32'(free_dw), 32'd0);
      chk("t3_ready",  32'(cmd_ready), 32'd0);
      chk("t3_valid",  32'(tlp_h_valid), 32'd0);
      chk("t3_outst",  32'(outstanding), 32'd2);
      release_tag(3'd0);
      step(1);
      chk("t3_valid_go", 32'(tlp_h_valid), 32'd1);
      chk("t3_free255",  32'(free_dw), 32'd255);
      step(1);
      release_tag(3'd1);
      release_tag(3'd0);
      chk("t3_free_end", 32'(free_dw), 32'd512);

      // Release and reservation interplay
      send_cmd(30'h2000, 10'd464, 3'd0, 1'b1);
      send_cmd(30'h2100, 10'd32,  3'd1, 1'b1);
      step(3);
      chk("t4_free16", 32'(free_dw), 32'd16);
      cpl_lookup_tag = 3'd0;
      #1 chk("t4_lookup", 32'(cpl_lookup_len), 32'd464);
      send_cmd(30'h2200, 10'd32, 3'd1, 1'b1);
      step(2);
      chk("t4_held", 32'(tlp_h_valid), 32'd0);
      release_tag(3'd1);
      chk("t4_no_issue_same", 32'(tlp_h_valid), 32'd0);
      chk("t4_free48",        32'(free_dw), 32'd48);
      step(1);
      chk("t4_issue",     32'(tlp_h_valid), 32'd1);
      chk("t4_tag1",      32'(tlp_h_tag), 32'd1);
      chk("t4_free16b",   32'(free_dw), 32'd16);
      chk("t4_outst2",    32'(outstanding), 32'd2);
      step(1);
      send_cmd(30'h2300, 10'd8, 3'd2, 1'b1);
      release_tag(3'd1);
      chk("t4_sim_free",  32'(free_dw), 32'd40);
      chk("t4_sim_outst", 32'(outstanding), 32'd2);
      chk("t4_sim_tag",   32'(tlp_h_tag), 32'd2);
      step(1);
      release_tag(3'd0);
      release_tag(3'd2);
      chk("t4_free_end", 32'(free_dw), 32'd512);

      // Backpressure with enable drop and release in flight
      send_cmd(30'h3000, 10'd64, 3'd0, 1'b1);
      step(3);
      tlp_h_ready = 1'b0;
      send_cmd(30'h5A5, 10'd10, 3'd1, 1'b1);
      step(1);
      for (int i = 0; i < 10; i++) begin
         if (i == 2) enable = 1'b0;
         cpl_done_tag   = 3'd0;
         cpl_done_valid = (i == 4);
         chk("t5_valid", 32'(tlp_h_valid), 32'd1);
         chk("t5_addr",  32'(tlp_h_addr), 32'h5A5);
         chk("t5_len",   32'(tlp_h_len), 32'd10);
         chk("t5_tag",   32'(tlp_h_tag), 32'd1);
         step(1);
      end
      cpl_done_valid = 1'b0;
      chk("t5_free502", 32'(free_dw), 32'd502);
      chk("t5_outst1",  32'(outstanding), 32'd1);
      tlp_h_ready = 1'b1;
      step(1);
      cmd_addr = 30'h3300; cmd_len = 10'd4; cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("t5_dis_ready", 32'(cmd_ready), 32'd0);
         chk("t5_dis_valid", 32'(tlp_h_valid), 32'd0);
         step(1);
      end
      cmd_valid = 1'b0;
      enable = 1'b1;
      step(3);
      chk("t5_no_hdr",   32'(tlp_h_valid), 32'd0);
      chk("t5_outst_ch", 32'(outstanding), 32'd1);
      release_tag(3'd1);
      chk("t5_free_end", 32'(free_dw), 32'd512);

      // Release of a free tag
      release_tag(3'd3);
      chk("t6_cpl_err",  32'(cpl_err), 32'd1);
      chk("t6_free",     32'(free_dw), 32'd512);
      chk("t6_outst",    32'(outstanding), 32'd0);
      step(1);
      chk("t6_cpl_err0", 32'(cpl_err), 32'd0);

      // Reset during issue
      tlp_h_ready = 1'b0;
      send_cmd(30'h4000, 10'd20, 3'd0, 1'b0);
      step(1);
      chk("t6_pre_valid", 32'(tlp_h_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_valid", 32'(tlp_h_valid), 32'd0);
      chk("t6_rst_free",  32'(free_dw), 32'd512);
      chk("t6_rst_outst", 32'(outstanding), 32'd0);
      chk("t6_rst_idle",  32'(idle), 32'd1);
      chk("t6_rst_ready", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      tlp_h_ready = 1'b1;
      step(3);
      chk("t6_post_valid", 32'(tlp_h_valid), 32'd0);
      send_cmd(30'h4100, 10'd4, 3'd0, 1'b1);
      step(3);
      chk("t6_post_free", 32'(free_dw), 32'd508);
      release_tag(3'd0);
      chk("t6_end_idle", 32'(idle), 32'd1);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dlsc_pcie_s6_outbound_read_alloc.md
Name: dlsc_pcie_s6_outbound_read_alloc

Overview:
Resource scheduler between the outbound read-request splitter and the PCIe TX header path.
- Holds each split read TLP header until a free tag and enough completion-buffer space are available.
- Stamps the header with the allocated tag and reserves the space.
- Releases both when the completion side reports that a tag has fully completed.
- Prevents completion-buffer overflow and tag reuse while completions are outstanding.

Parameters:
ADDR, 32, address width (byte address; ports carry [ADDR-1:2]).
TAG, 3, log2 of tag count (TAGS = 2**TAG, range 1..5).
CPL_BUF_DW, 512, completion buffer capacity in DW; must be ≥ largest cmd_len used and ≤ 4096.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  bus-master enable; gates acceptance of new commands
cmd_ready  out  1  command accept
cmd_valid  in  1  command valid
cmd_addr  in  ADDR-2  DW address
cmd_len  in  10  length in DW; 0 encodes 1024
tlp_h_ready  in  1  TX header accept
tlp_h_valid  out  1  TX header valid
tlp_h_addr  out  ADDR-2  DW address
tlp_h_len  out  10  length (same encoding as cmd_len)
tlp_h_tag  out  TAG  allocated tag
cpl_done_valid  in  1  single-cycle pulse: tag fully completed
cpl_done_tag  in  TAG  tag being released
cpl_lookup_tag  in  TAG  tag to query
cpl_lookup_len  out  10  stored length for cpl_lookup_tag (combinational read)
outstanding  out  TAG+1  number of busy tags
free_dw  out  13  unreserved completion-buffer DW
idle  out  1  no tags busy and FSM in ST_IDLE
cpl_err  out  1  one-cycle pulse: release of a non-busy tag

Behaviour:
- Reset (async, active-high): FSM=ST_IDLE; cmd_ready=0, tlp_h_valid=0, tag_busy all 0, outstanding=0, free_dw=CPL_BUF_DW, idle=1, cpl_err=0. Header registers and len RAM are not reset.
- Reset mid-operation: all tags free, any held command dropped, no header emitted.
- FSM states: ST_IDLE, ST_HOLD, ST_ISSUE.
- ST_IDLE:
  - cmd_ready = enable.
  - On cmd handshake: latch addr/len and go to ST_HOLD.
- ST_HOLD:
  - Compute len_dw = (cmd_len==0) ? 1024 : cmd_len, 11 bits.
  - Resources ok when any tag is free (registered bitmap) AND len_dw ≤ free_dw.
  - When ok: pick the lowest-numbered free tag; set busy bit; store len in len RAM; free_dw -= len_dw; outstanding += 1; go to ST_ISSUE.
  - Otherwise stay in ST_HOLD indefinitely.
  - enable is ignored once a command has been latched.
- ST_ISSUE:
  - tlp_h_valid=1 (registered); addr/len/tag stable until tlp_h_ready.
  - On handshake: go to ST_IDLE (tlp_h_valid=0 next cycle).
  - Valid is never withdrawn.
- Latency: cmd accepted in cycle N → tlp_h_valid earliest N+2. Minimum 3 cycles per command.
- Release: on cpl_done_valid with a busy tag → busy bit cleared; free_dw += stored len (0 counts as 1024); outstanding -= 1.
- Release with a non-busy tag → no state change; cpl_err pulses next cycle.
- Same cycle release and reservation: both applied.
  - free_dw = free_dw − res + rel.
  - outstanding unchanged.
  - The tag released that cycle is not eligible for allocation until the following cycle, because selection uses the registered bitmap.
- A release arriving during ST_ISSUE does not affect the header in flight (resources were already reserved).
- free_dw never exceeds CPL_BUF_DW. Exceeding it is only possible through a double release, which is blocked by the busy check.
- cpl_lookup_len is an asynchronous read of len RAM and is undefined for non-busy tags.

Test Plan:
- Reset then single cmd addr=0x1000>>2, len=32 with tlp_h_ready=1 → tlp_h_valid at N+2, tag=0, free_dw=480, outstanding=1; cpl_done tag 0 → free_dw=512, idle=1.
- Issue 8 cmds of len=16 without releases (TAG=3) → tags 0..7, outstanding=8. 9th command stalls in ST_HOLD, cmd_ready=0. Release tag 5 → 9th issues with tag 5 two cycles later.
- CPL_BUF_DW=512: cmds len=256, 256, then 1 → third stalls with free_dw=0. Release tag 0 → third issues, free_dw=255.
- Release and reservation in the same cycle (free_dw=16, held len=32, release of a len=32 tag) → the held command does not issue that cycle. It issues the next cycle, leaving free_dw=16; the freed tag is allocated on that later cycle.
- tlp_h_ready held low 10 cycles in ST_ISSUE while enable drops and a release occurs → valid, addr, len and tag stay stable; header sent on ready; no new cmd accepted while enable=0.
- cpl_done on a free tag → cpl_err one-cycle pulse, counters unchanged. Assert rst mid-ST_ISSUE → tlp_h_valid drops immediately, free_dw=512.
